flex_down_timer: RTL

- Programmable down-counting timer; the count-down counterpart of the team's up-counting rollover counter.
- Loaded with a period, it decrements on enabled ticks and flags expiry.
- Either re-arms itself (periodic mode) or stops and holds (one-shot mode).
- Used by the pixel pipeline for line/frame blanking intervals and handshake timeouts.

---
 rtl/flex_timer_pkg.sv | 12 +
 rtl/flex_down_timer_prescaler.sv | 31 +++
 rtl/flex_down_timer.sv | 93 +++++++++
 3 files changed

// File: rtl/flex_timer_pkg.sv
// Shared types for the flex_down_timer block: state encoding of the timer FSM.
package flex_timer_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

endpackage

// File: rtl/flex_down_timer_prescaler.sv
// timer_prescaler: counts enabled cycles and pulses tick_out on every DIV-th one.
// Instantiated by flex_down_timer only when FLEX_DOWN_TIMER_PRESCALE_EN is defined.
module timer_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic n_rst,
    input  logic sync_clr,
    input  logic enable,
    output logic tick_out
);

    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] phase;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase <= '0;
        end else if (sync_clr) begin
            phase <= '0;
        end else if (enable) begin
            phase <= (phase == LAST) ? '0 : phase + 1'b1;
        end
    end

    // Combinational pulse: the timer registers it in the same cycle it is produced.
    assign tick_out = enable && (phase == LAST);

endmodule

// File: rtl/flex_down_timer.sv
// flex_down_timer: loadable down-counting timer with one-shot / periodic expiry.
// Optional prescaler enabled by defining FLEX_DOWN_TIMER_PRESCALE_EN.
module flex_down_timer
    import flex_timer_pkg::*;
#(
    parameter int NUM_CNT_BITS = 4,
    parameter int PRESCALE_DIV = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    load,
    input  logic [NUM_CNT_BITS-1:0] load_val,
    input  logic                    count_enable,
    input  logic                    auto_reload,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    zero_flag,
    output logic                    busy
);

    localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);

    if (PRESCALE_DIV < 2 || PRESCALE_DIV > 256) begin : g_bad_div
        $error("flex_down_timer: PRESCALE_DIV must be in 2..256");
    end

    timer_state_t              state;
    logic [NUM_CNT_BITS-1:0]   reload;
    logic                      tick;

`ifdef FLEX_DOWN_TIMER_PRESCALE_EN
    timer_prescaler #(
        .DIV (PRESCALE_DIV)
    ) u_prescaler (
        .clk      (clk),
        .n_rst    (n_rst),
        .sync_clr (clear | load),
        .enable   (count_enable && (state == RUN)),
        .tick_out (tick)
    );
`else
    assign tick = count_enable;
`endif

    // NOTE: clear returns to IDLE but keeps the reload register, so only load changes the period.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            count_out <= '0;
            reload    <= '0;
            zero_flag <= 1'b0;
            busy      <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            count_out <= '0;
            zero_flag <= 1'b0;
            busy      <= 1'b0;
        end else if (load) begin
            reload    <= load_val;
            count_out <= load_val;
            zero_flag <= 1'b0;
            if (load_val != '0) begin
                state <= RUN;
                busy  <= 1'b1;
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end else begin
            case (state)
                RUN: begin
                    zero_flag <= 1'b0;
                    if (tick) begin
                        if (count_out > ONE) begin
                            count_out <= count_out - ONE;
                        end else if (auto_reload) begin
                            count_out <= reload;
                            zero_flag <= 1'b1;
                        end else begin
                            count_out <= '0;
                            zero_flag <= 1'b1;
                            state     <= EXPIRED;
                            busy      <= 1'b0;
                        end
                    end
                end
                // IDLE and EXPIRED hold everything, including a sticky zero_flag.
                default: ;
            endcase
        end
    end

endmodule
